// File: rtl/botones_leds_debounce_pkg.sv
// Shared constants for the button debounce / LED driver slice.
// Buttons are active-low on the board: 0 means pressed.
package botones_leds_debounce_pkg;

   localparam int   NUM_BTN                 = 4;
   localparam int   DEFAULT_DEBOUNCE_CYCLES = 12000;
   localparam logic BTN_PRESSED             = 1'b0;
   localparam logic BTN_RELEASED            = 1'b1;

endpackage

// File: rtl/botones_leds_debounce_boton_debounce.sv
// One button: 2-FF synchronizer, debounce counter, stable level and press pulse.
// led_cmd_o is a toggle request with LED_TOGGLE_EN, otherwise the debounced pressed level.
module boton_debounce
   import botones_leds_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic boton_i,
   output logic press_o,
   output logic led_cmd_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic             stable_dly_q, stable_dly_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d      = boton_i;
      sync2_d      = sync1_q;
      stable_d     = stable_q;
      stable_dly_d = stable_q;
      cnt_d        = cnt_q;
      // Bound check precedes increment, so the counter never wraps.
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      press_d = (stable_dly_q == BTN_RELEASED) && (stable_q == BTN_PRESSED);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q      <= BTN_RELEASED;
         sync2_q      <= BTN_RELEASED;
         stable_q     <= BTN_RELEASED;
         stable_dly_q <= BTN_RELEASED;
         cnt_q        <= '0;
         press_q      <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
         cnt_q        <= cnt_d;
         press_q      <= press_d;
      end
   end

   assign press_o = press_q;

`ifdef LED_TOGGLE_EN
   assign led_cmd_o = press_d;
`else
   assign led_cmd_o = (stable_q == BTN_PRESSED);
`endif

endmodule

// File: rtl/botones_leds_debounce.sv
// Four debounced active-low buttons driving PRESS pulses and the board LEDs.
// Optional macro LED_TOGGLE_EN: LEDs toggle per press instead of mirroring the held state.
module botones_leds_debounce
   import botones_leds_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic BOTON0,
   input  logic BOTON1,
   input  logic BOTON2,
   input  logic BOTON3,
   output logic LED0,
   output logic LED1,
   output logic LED2,
   output logic LED3,
   output logic PRESS0,
   output logic PRESS1,
   output logic PRESS2,
   output logic PRESS3
);

   logic [NUM_BTN-1:0] boton;
   logic [NUM_BTN-1:0] press;
   logic [NUM_BTN-1:0] led_cmd;
   logic [NUM_BTN-1:0] led_q, led_d;

   assign boton = {BOTON3, BOTON2, BOTON1, BOTON0};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      boton_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_btn (
         .clk      (clk),
         .rstn     (rstn),
         .boton_i  (boton[i]),
         .press_o  (press[i]),
         .led_cmd_o(led_cmd[i])
      );
   end

   always_comb begin
`ifdef LED_TOGGLE_EN
      led_d = led_q ^ led_cmd;
`else
      led_d = led_cmd;
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         led_q <= '0;
      end else begin
         led_q <= led_d;
      end
   end

   assign {LED3, LED2, LED1, LED0}         = led_q;
   assign {PRESS3, PRESS2, PRESS1, PRESS0} = press;

endmodule

// File: tb/tb_botones_leds_debounce.sv
// Randomised and directed bench for botones_leds_debounce with a queue scoreboard
// fed by a sample-history reference model.
module tb_botones_leds_debounce;

  localparam int D  = 4;
  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] boton;
  logic       led0, led1, led2, led3;
  logic       press0, press1, press2, press3;

  always #50 clk = ~clk;

  botones_leds_debounce #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .BOTON0(boton[0]),
    .BOTON1(boton[1]),
    .BOTON2(boton[2]),
    .BOTON3(boton[3]),
    .LED0  (led0),
    .LED1  (led1),
    .LED2  (led2),
    .LED3  (led3),
    .PRESS0(press0),
    .PRESS1(press1),
    .PRESS2(press2),
    .PRESS3(press3)
  );

  // Scoreboard: one entry per clock edge, {led[3:0], press[3:0]}.
  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: a button's debounced level flips once the D most recent
  // synchronised samples (sampled two edges earlier) all disagree with it.
  bit samp[NB][$];
  bit st[NB];
  bit st_prev[NB];
  bit led_m[NB];
  int press_m[NB];
  int press_seen[NB];

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      samp[i].delete();
      for (int j = 0; j < D + 2; j++) samp[i].push_back(1'b1);
      st[i]      = 1'b1;
      st_prev[i] = 1'b1;
      led_m[i]   = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      press_m[i]    = 0;
      press_seen[i] = 0;
    end
    model_reset();
  end

  always @(posedge clk) begin : model
    logic [3:0] led_e, press_e;
    bit cur, all_diff;
    int sz;
    led_e   = 4'h0;
    press_e = 4'h0;
    if (!rstn) begin
      model_reset();
    end else begin
      for (int i = 0; i < NB; i++) begin
        cur      = st[i];
        all_diff = 1'b1;
        sz       = samp[i].size();
        for (int j = 2; j <= D + 1; j++)
          if (samp[i][sz-j] == cur) all_diff = 1'b0;
        press_e[i] = st_prev[i] & ~cur;
`ifdef LED_TOGGLE_EN
        led_m[i] = led_m[i] ^ press_e[i];
`else
        led_m[i] = ~cur;
`endif
        led_e[i]   = led_m[i];
        st_prev[i] = cur;
        st[i]      = all_diff ? ~cur : cur;
        samp[i].push_back(boton[i]);
        void'(samp[i].pop_front());
        if (press_e[i]) press_m[i]++;
      end
    end
    exp_q.push_back({led_e, press_e});
  end

  always @(negedge clk) begin : monitor
    logic [7:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rstn) e = 8'h00;
      a = {led3, led2, led1, led0, press3, press2, press1, press0};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL out_vec t=%0t actual=%h required=%h", $time, a, e);
      end
      for (int i = 0; i < NB; i++) if (a[i] === 1'b1) press_seen[i]++;
    end
  end

  task automatic drive(input logic [3:0] b, input int n);
    boton = b;
    repeat (n) begin
      @(posedge clk);
      #20;
    end
  endtask

  task automatic pulse_reset(input int n);
    rstn = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #20;
    end
    rstn = 1'b1;
  endtask

  initial begin
    int guard;
    rstn  = 1'b0;
    boton = 4'hF;
    repeat (3) begin
      @(posedge clk);
      #20;
    end
    rstn = 1'b1;

    drive(4'hF, 20);                       // idle after reset
    drive(4'hE, 10); drive(4'hF, 12);      // clean press BTN0
    drive(4'hD, 3);  drive(4'hF, 10);      // glitch BTN1, rejected
    drive(4'hD, 4);  drive(4'hF, 12);      // minimum accepted press BTN1
    for (int j = 0; j < 8; j++)            // bounce BTN2, then settle low
      drive((j % 2 == 0) ? 4'hB : 4'hF, 1);
    drive(4'hB, 10); drive(4'hF, 12);
    drive(4'h6, 10); drive(4'hF, 12);      // BTN0 + BTN3 together
    drive(4'hE, 10); drive(4'hF, 12);      // second BTN0 press
    drive(4'hB, 4);                        // BTN2 mid-count, then reset
    pulse_reset(3);
    drive(4'hB, 10); drive(4'hF, 12);

    repeat (60) begin
      drive(4'($urandom_range(0, 15)), $urandom_range(1, 8));
      if ($urandom_range(0, 19) == 0) pulse_reset($urandom_range(1, 3));
    end
    drive(4'hF, 15);

    guard = 0;
    while (exp_q.size() > 1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() > 1) begin
      bad++;
      $display("FAIL drain actual=%0d required<=1", exp_q.size());
    end
    for (int i = 0; i < NB; i++) begin
      total++;
      if (press_seen[i] != press_m[i]) begin
        bad++;
        $display("FAIL press_count%0d actual=%0d required=%0d", i, press_seen[i], press_m[i]);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
